// File: rtl/imul_sched.sv
// imul_sched: round-robin arbiter feeding the shared pipelined multiplier.
// Tracks in-flight tag/port through a latency-matched valid pipe.
module imul_sched #(
    parameter int NREQ = 3,
    parameter int LAT  = 4,
    parameter int TAGW = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clkEn,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req_en,
    input  logic [NREQ*13-1:0]     req_op,
    input  logic [NREQ*65-1:0]     req_A,
    input  logic [NREQ*65-1:0]     req_B,
    input  logic [NREQ*TAGW-1:0]   req_tag,
    output logic [NREQ-1:0]        grant,
    output logic                   mul_en,
    output logic [12:0]            mul_op,
    output logic [64:0]            mul_R,
    output logic [64:0]            mul_C,
    output logic                   res_valid,
    output logic [TAGW-1:0]        res_tag,
    output logic [1:0]             res_port,
    output logic                   busy,
    output logic [15:0]            issue_cnt
);

    localparam int PW = 2;

    logic [PW-1:0]          ptr;
    logic [PW-1:0]          ptr_nxt;
    logic [PW-1:0]          gidx;
    logic                   hit;
    logic [2:0]             cand;

    logic [12:0]            sel_op;
    logic [64:0]            sel_A;
    logic [64:0]            sel_B;
    logic [TAGW-1:0]        sel_tag;

    logic [TAGW-1:0]        mul_tag;
    logic [1:0]             mul_port;

    logic [LAT:1]           pv;
    logic [LAT:1][TAGW-1:0] pt;
    logic [LAT:1][1:0]      pp;

    // Scan upward from the pointer, wrapping, for the first requester.
    always_comb begin
        grant = '0;
        gidx  = '0;
        hit   = 1'b0;
        cand  = '0;
        if (!rst && !flush && clkEn) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = 3'(ptr) + 3'(k);
                if (cand >= 3'(NREQ))
                    cand = cand - 3'(NREQ);
                if (!hit && req_en[cand[PW-1:0]]) begin
                    hit  = 1'b1;
                    gidx = cand[PW-1:0];
                end
            end
            if (hit)
                grant[gidx] = 1'b1;
        end
    end

    // Mux the granted port's fields and compute the advanced pointer.
    always_comb begin
        sel_op  = '0;
        sel_A   = '0;
        sel_B   = '0;
        sel_tag = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant[j]) begin
                sel_op  = req_op[j*13 +: 13];
                sel_A   = req_A[j*65 +: 65];
                sel_B   = req_B[j*65 +: 65];
                sel_tag = req_tag[j*TAGW +: TAGW];
            end
        end
        if (gidx == PW'(NREQ - 1))
            ptr_nxt = '0;
        else
            ptr_nxt = gidx + 1'b1;
    end

    // Operand register stage, pointer and issue counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_en    <= 1'b0;
            mul_op    <= '0;
            mul_R     <= '0;
            mul_C     <= '0;
            mul_tag   <= '0;
            mul_port  <= '0;
            ptr       <= '0;
            issue_cnt <= '0;
        end else if (flush) begin
            mul_en <= 1'b0;
        end else if (clkEn) begin
            if (hit) begin
                mul_en   <= 1'b1;
                mul_op   <= sel_op;
                mul_R    <= sel_A;
                mul_C    <= sel_B;
                mul_tag  <= sel_tag;
                mul_port <= 2'(gidx);
                ptr      <= ptr_nxt;
                if (issue_cnt != 16'hFFFF)
                    issue_cnt <= issue_cnt + 16'd1;
            end else begin
                mul_en <= 1'b0;
            end
        end
    end

    // Valid/tag/port shift pipe that mirrors the multiplier latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv <= '0;
            pt <= '0;
            pp <= '0;
        end else if (flush) begin
            pv <= '0;
        end else if (clkEn) begin
            pv[1] <= mul_en;
            pt[1] <= mul_tag;
            pp[1] <= mul_port;
            for (int s = 2; s <= LAT; s++) begin
                pv[s] <= pv[s-1];
                pt[s] <= pt[s-1];
                pp[s] <= pp[s-1];
            end
        end
    end

    // A stalled final stage is masked so it pulses once when released.
    always_comb begin
        res_valid = pv[LAT] & clkEn;
        res_tag   = pt[LAT];
        res_port  = pp[LAT];
        busy      = mul_en | (|pv);
    end

endmodule
